// File: rtl/alarm_pkg.sv
// Shared types for the alarm siren sequencer: state encoding and its width.
package alarm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED = 3'd0,
    ST_ARMING   = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_SOUNDING = 3'd4,
    ST_LATCHED  = 3'd5
  } state_t;

endpackage

// File: rtl/alarm_siren_ctrl_if.sv
// Control/status bundle between the alarm system and the siren sequencer.
// master: the side that drives enable/alarm_in; slave: the sequencer.
interface alarm_siren_ctrl_if import alarm_pkg::*; ();

  logic               enable;
  logic               alarm_in;
  logic               siren;
  logic               armed_led;
  logic               tripped;
  logic [STATE_W-1:0] state;

  modport master (
    output enable,
    output alarm_in,
    input  siren,
    input  armed_led,
    input  tripped,
    input  state
  );

  modport slave (
    input  enable,
    input  alarm_in,
    output siren,
    output armed_led,
    output tripped,
    output state
  );

endinterface

// File: rtl/alarm_timer.sv
// Loadable down-counter that stops at zero; load has priority over dec.
module alarm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Count register: load wins, decrement only while nonzero (no wrap).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_siren_ctrl.sv
// Alarm siren sequencer: exit delay, entry delay, time-limited siren and a
// sticky tripped flag. Optional macro ALARM_STROBE_EN pulses the siren with
// a STROBE_HALF-cycle half-period instead of driving it steady.
module alarm_siren_ctrl import alarm_pkg::*; #(
  parameter int EXIT_CYCLES  = 8,
  parameter int ENTRY_CYCLES = 6,
  parameter int SIREN_CYCLES = 16,
  parameter int STROBE_HALF  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alarm_siren_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (EXIT_CYCLES > ENTRY_CYCLES)
                         ? ((EXIT_CYCLES > SIREN_CYCLES) ? EXIT_CYCLES : SIREN_CYCLES)
                         : ((ENTRY_CYCLES > SIREN_CYCLES) ? ENTRY_CYCLES : SIREN_CYCLES);
  localparam int TW = $clog2(MAX_CYC) + 1;

  // A state loaded with N-1 lasts N cycles: it leaves on the edge where the
  // timer reads zero.
  localparam logic [TW-1:0] EXIT_LD  = TW'(EXIT_CYCLES - 1);
  localparam logic [TW-1:0] ENTRY_LD = TW'(ENTRY_CYCLES - 1);
  localparam logic [TW-1:0] SIREN_LD = TW'(SIREN_CYCLES - 1);

  state_t          state_q, state_d;
  logic            t_load, t_dec, t_zero;
  logic [TW-1:0]   t_val;
  logic            siren_q, siren_d;
  logic            armed_q, armed_d;
  logic            tripped_q, tripped_d;
  logic            enter_snd;

  alarm_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  // Next-state and timer control; disarm overrides everything.
  always_comb begin
    state_d = ST_DISARMED;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;
    if (!bus.enable) begin
      state_d = ST_DISARMED;
      t_load  = 1'b1;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          state_d = ST_ARMING;
          t_load  = 1'b1;
          t_val   = EXIT_LD;
        end
        ST_ARMING: begin
          if (t_zero) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_ARMING;
            t_dec   = 1'b1;
          end
        end
        ST_ARMED: begin
          if (bus.alarm_in) begin
            state_d = ST_ENTRY;
            t_load  = 1'b1;
            t_val   = ENTRY_LD;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_ENTRY: begin
          if (t_zero) begin
            state_d = ST_SOUNDING;
            t_load  = 1'b1;
            t_val   = SIREN_LD;
          end else begin
            state_d = ST_ENTRY;
            t_dec   = 1'b1;
          end
        end
        ST_SOUNDING: begin
          if (t_zero) begin
            state_d = ST_LATCHED;
          end else begin
            state_d = ST_SOUNDING;
            t_dec   = 1'b1;
          end
        end
        ST_LATCHED: begin
          // Re-trigger skips the entry delay.
          if (bus.alarm_in) begin
            state_d = ST_SOUNDING;
            t_load  = 1'b1;
            t_val   = SIREN_LD;
          end else begin
            state_d = ST_LATCHED;
          end
        end
        default: begin
          state_d = ST_DISARMED;
          t_load  = 1'b1;
        end
      endcase
    end
  end

  assign enter_snd = (state_d == ST_SOUNDING) && (state_q != ST_SOUNDING);

`ifdef ALARM_STROBE_EN
  localparam int SW = $clog2(STROBE_HALF) + 1;
  localparam logic [SW-1:0] PH_LAST = SW'(STROBE_HALF - 1);

  logic [SW-1:0] ph_cnt_q, ph_cnt_d;
  logic          ph_lvl_q, ph_lvl_d;

  // Strobe phase: restart high on entry to SOUNDING, flip every STROBE_HALF cycles.
  always_comb begin
    ph_cnt_d = '0;
    ph_lvl_d = 1'b0;
    if (state_d == ST_SOUNDING) begin
      if (enter_snd) begin
        ph_cnt_d = '0;
        ph_lvl_d = 1'b1;
      end else if (ph_cnt_q == PH_LAST) begin
        ph_cnt_d = '0;
        ph_lvl_d = ~ph_lvl_q;
      end else begin
        ph_cnt_d = ph_cnt_q + 1'b1;
        ph_lvl_d = ph_lvl_q;
      end
    end
  end

  // Strobe phase registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_cnt_q <= '0;
      ph_lvl_q <= 1'b0;
    end else begin
      ph_cnt_q <= ph_cnt_d;
      ph_lvl_q <= ph_lvl_d;
    end
  end

  assign siren_d = (state_d == ST_SOUNDING) && ph_lvl_d;
`else
  // Steady siren; the strobe period has no effect in this build.
  logic unused_strobe_half;
  assign unused_strobe_half = ^STROBE_HALF;
  assign siren_d = (state_d == ST_SOUNDING);
`endif

  // Output values computed from the next state so the registers line up with it.
  always_comb begin
    armed_d   = state_d inside {ST_ARMED, ST_ENTRY, ST_SOUNDING, ST_LATCHED};
    tripped_d = 1'b0;
    if (state_d != ST_DISARMED) begin
      tripped_d = tripped_q || enter_snd;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_DISARMED;
      siren_q   <= 1'b0;
      armed_q   <= 1'b0;
      tripped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      siren_q   <= siren_d;
      armed_q   <= armed_d;
      tripped_q <= tripped_d;
    end
  end

  assign bus.siren     = siren_q;
  assign bus.armed_led = armed_q;
  assign bus.tripped   = tripped_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Bench for alarm_siren_ctrl with EXIT=4, ENTRY=3, SIREN=6, STROBE_HALF=2.
module tb_alarm_siren_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  alarm_siren_ctrl_if sif ();

  alarm_siren_ctrl #(
    .EXIT_CYCLES  (4),
    .ENTRY_CYCLES (3),
    .SIREN_CYCLES (6),
    .STROBE_HALF  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

`ifdef ALARM_STROBE_EN
  localparam logic [5:0] SPAT = 6'b110011;
`else
  localparam logic [5:0] SPAT = 6'b111111;
`endif

  typedef struct packed {
    logic       rn;
    logic       en;
    logic       al;
    logic [2:0] st;
    logic       si;
    logic       led;
    logic       tr;
  } vec_t;

  typedef struct packed {
    logic [2:0] st;
    logic       si;
    logic       led;
    logic       tr;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [5:0] spat;

  function automatic void add(input logic rn, input logic en, input logic al,
                              input logic [2:0] st, input logic si,
                              input logic led, input logic tr);
    vec_t v;
    v.rn = rn; v.en = en; v.al = al;
    v.st = st; v.si = si; v.led = led; v.tr = tr;
    vecs.push_back(v);
  endfunction

  // Four ARMING cycles then ARMED, starting from DISARMED with enable high.
  function automatic void add_arm();
    for (int k = 0; k < 4; k++) add(1, 1, 0, 3'd1, 0, 0, 0);
    add(1, 1, 0, 3'd2, 0, 1, 0);
  endfunction

  task automatic check_bit(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e, a;
    int   n, cyc, hi;

    spat         = SPAT;
    rst_n        = 1'b0;
    sif.enable   = 1'b0;
    sif.alarm_in = 1'b0;

    // reset
    add(0, 0, 0, 3'd0, 0, 0, 0);
    add(0, 0, 0, 3'd0, 0, 0, 0);
    // arm; alarm pulses during ARMING are ignored; ARMED on 5th edge
    add(1, 1, 0, 3'd1, 0, 0, 0);
    add(1, 1, 1, 3'd1, 0, 0, 0);
    add(1, 1, 1, 3'd1, 0, 0, 0);
    add(1, 1, 0, 3'd1, 0, 0, 0);
    add(1, 1, 0, 3'd2, 0, 1, 0);
    add(1, 1, 0, 3'd2, 0, 1, 0);
    // trigger: ENTRY x3, SOUNDING x6, LATCHED
    add(1, 1, 1, 3'd3, 0, 1, 0);
    add(1, 1, 0, 3'd3, 0, 1, 0);
    add(1, 1, 0, 3'd3, 0, 1, 0);
    for (int k = 0; k < 6; k++) add(1, 1, 0, 3'd4, spat[k], 1, 1);
    add(1, 1, 0, 3'd5, 0, 1, 1);
    add(1, 1, 0, 3'd5, 0, 1, 1);
    // re-trigger from LATCHED: straight to SOUNDING for 6 cycles
    add(1, 1, 1, 3'd4, spat[0], 1, 1);
    for (int k = 1; k < 6; k++) add(1, 1, 0, 3'd4, spat[k], 1, 1);
    add(1, 1, 0, 3'd5, 0, 1, 1);
    // re-trigger, then disarm mid-SOUNDING: siren drops with no tail
    add(1, 1, 1, 3'd4, spat[0], 1, 1);
    add(1, 0, 0, 3'd0, 0, 0, 0);
    // disarm during ENTRY: siren never asserts, tripped stays 0
    add_arm();
    add(1, 1, 1, 3'd3, 0, 1, 0);
    add(1, 1, 0, 3'd3, 0, 1, 0);
    add(1, 0, 0, 3'd0, 0, 0, 0);
    // enable falls and alarm rises on the same edge in ARMED: disarm wins
    add_arm();
    add(1, 0, 1, 3'd0, 0, 0, 0);
    // reset during SOUNDING, then re-arm with enable held
    add_arm();
    add(1, 1, 1, 3'd3, 0, 1, 0);
    add(1, 1, 0, 3'd3, 0, 1, 0);
    add(1, 1, 0, 3'd3, 0, 1, 0);
    add(1, 1, 0, 3'd4, spat[0], 1, 1);
    add(1, 1, 0, 3'd4, spat[1], 1, 1);
    add(0, 1, 0, 3'd0, 0, 0, 0);
    add(1, 1, 0, 3'd1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n        = vecs[i].rn;
      sif.enable   = vecs[i].en;
      sif.alarm_in = vecs[i].al;
      exp_q.push_back({vecs[i].st, vecs[i].si, vecs[i].led, vecs[i].tr});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      a = {sif.state, sif.siren, sif.armed_led, sif.tripped};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d: got st=%0d si=%0b led=%0b tr=%0b, required st=%0d si=%0b led=%0b tr=%0b",
                 i, a.st, a.si, a.led, a.tr, e.st, e.si, e.led, e.tr);
      end
    end

    // Wait (bounded) for ARMED from the ARMING state left by the table.
    n = 0;
    while (sif.state != 3'd2 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_bit("reach_armed", int'(sif.state), 2);

    // ARMED -> SOUNDING takes ENTRY_CYCLES+1 edges from the alarm sample.
    @(negedge clk);
    sif.alarm_in = 1'b1;
    @(posedge clk); #1;
    sif.alarm_in = 1'b0;
    n = 1;
    while (sif.state != 3'd4 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_bit("entry_latency", n, 4);

    // Siren duration and high-cycle count over one SOUNDING episode.
    cyc = 0;
    hi  = 0;
    while (sif.state == 3'd4 && cyc < 30) begin
      if (sif.siren) hi++;
      cyc++;
      @(posedge clk); #1;
    end
    check_bit("sounding_len", cyc, 6);
    check_bit("siren_high", hi, $countones(spat));
    check_bit("latched_state", int'(sif.state), 5);
    check_bit("latched_tripped", int'(sif.tripped), 1);
    check_bit("latched_siren", int'(sif.siren), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
